// File: rtl/aes_pkg.sv
// Shared AES constants: byte count, inverse S-box table and the
// state type of the iterative InvSubBytes engine.
package aes_pkg;

  localparam int AES_NUM_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } isb_state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);

  assign result = INV_SBOX[value];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: a 128-bit state is substituted BPC bytes per cycle
// through shared inverse S-box lanes and returned over a valid/ready handshake.
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] result,
  output logic         out_valid,
  input  logic         out_ready
);
  // state | meaning
  // IDLE  | waiting for a block, in_ready=1
  // BUSY  | substituting byte group r_cnt of the work register
  // DONE  | presenting result until out_ready

  localparam int NUM_GRP = AES_NUM_BYTES / BPC;
  localparam int CNT_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_GRP - 1);
  localparam int LANE_W = BPC * 8;

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
    $error("inv_sub_bytes_iter: BPC=%0d must be one of 1,2,4,8,16", BPC);
  end

  isb_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [127:0]       r_work;
  logic [6:0]         w_base;
  logic [LANE_W-1:0]  w_grp_in;
  logic [LANE_W-1:0]  w_grp_out;

  // Bit offset of the current group; with BPC=16 r_cnt is always 0.
  assign w_base   = 7'(r_cnt) * 7'(LANE_W);
  assign w_grp_in = r_work[w_base +: LANE_W];

  for (genvar g = 0; g < BPC; g++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .value  (w_grp_in[8*g +: 8]),
      .result (w_grp_out[8*g +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work  <= in;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_work[w_base +: LANE_W] <= w_grp_out;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_GRP) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  // Partially substituted contents never leave the block.
  assign result    = (r_state == DONE) ? r_work : '0;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboard bench for inv_sub_bytes_iter: the reference S-box is derived from
// GF(2^8) inversion plus the affine map, and every block must round-trip.
module tb_inv_sub_bytes_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, rst_s, sweep_go;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_d, result;
  int           rdy_mode = 0;
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] exp_q [$];

  inv_sub_bytes_iter #(.BPC(4)) u_dut (
    .clk(clk), .rst(rst), .in(in_d), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from its definition: multiplicative inverse then affine map.
  function automatic void build_model();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[8*k +: 8] = sbox_m[x[8*k +: 8]];
    return y;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic send(input logic [127:0] data, input logic [127:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end
    in_d = data;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_ready !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s_timeout: pending=%0d expected 0", name, exp_q.size());
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_main: unexpected result %h, expected none", result);
      end else begin
        check128("sb_main", result, exp_q.pop_front());
      end
    end
  end

  // Other lane widths run random round trips concurrently on their own reset.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int SB = (gi < 2) ? (1 << gi) : (1 << (gi + 1));
    logic [127:0] s_in, s_res, sx;
    logic         s_iv, s_ir, s_ov, s_or, done;
    logic [127:0] q [$];
    int           n;

    inv_sub_bytes_iter #(.BPC(SB)) u_dut (
      .clk(clk), .rst(rst_s), .in(s_in), .in_valid(s_iv), .in_ready(s_ir),
      .result(s_res), .out_valid(s_ov), .out_ready(s_or)
    );

    always @(posedge clk) begin
      #2 s_or = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
      if (rst_s === 1'b0 && s_ov === 1'b1 && s_or === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_bpc%0d: unexpected result %h, expected none", SB, s_res);
        end else begin
          check128($sformatf("sb_bpc%0d", SB), s_res, q.pop_front());
        end
      end
    end

    initial begin
      done = 1'b0; s_iv = 1'b0; s_in = '0;
      wait (sweep_go === 1'b1);
      for (int v = 0; v < 200; v++) begin
        sx = rand128();
        n = 0;
        @(negedge clk);
        while (s_ir !== 1'b1 && n < 200) begin
          @(negedge clk);
          n++;
        end
        if (n >= 200) begin
          checks++; errors++;
          $display("FAIL send_bpc%0d_timeout: in_ready=%b expected 1", SB, s_ir);
        end
        s_in = sub_bytes(sx);
        s_iv = 1'b1;
        @(posedge clk);
        q.push_back(sx);
        #1 s_iv = 1'b0;
      end
      n = 0;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL drain_bpc%0d_timeout: pending=%0d expected 0", SB, q.size());
      end
      done = 1'b1;
    end
  end

  initial begin
    logic [127:0] x;
    logic [4:0]   ov_seen;
    int           n;
    rst = 1'b1; rst_s = 1'b1; sweep_go = 1'b0;
    in_valid = 1'b0; in_d = '0;
    build_model();

    // Reset and idle behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("reset_in_ready", in_ready, 1'b1);
    check1("reset_out_valid", out_valid, 1'b0);
    check128("reset_result", result, 128'h0);
    rst = 1'b0; rst_s = 1'b0; sweep_go = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_d = rand128();
      @(negedge clk);
      check1("idle_in_ready", in_ready, 1'b1);
      check1("idle_out_valid", out_valid, 1'b0);
    end
    check128("idle_result", result, 128'h0);

    // Known single bytes and handshake-to-valid latency
    send({{11{8'h63}}, 40'hED_16_00_7C_63}, {88'h0, 40'h53_FF_52_01_00});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ov_seen[c] = out_valid;
    end
    check1("latency_cycle4_low", ov_seen[3], 1'b0);
    check1("latency_cycle5_high", ov_seen[4], 1'b1);
    wait_idle("single_bytes");

    // FIPS-197 round 1: SubBytes output back to start-of-round state
    send(128'h30_52_41_1e_e5_5d_b4_b8_f1_98_bf_e0_ae_11_27_d4,
         128'h08_48_f8_e9_2a_8d_c6_9a_2b_e2_f4_a0_be_e3_3d_19);
    wait_idle("fips");

    // Random round trips with random downstream readiness
    rdy_mode = 1;
    for (int v = 0; v < 200; v++) begin
      x = rand128();
      send(sub_bytes(x), x);
    end
    wait_idle("random");

    // Backpressure: result held, new inputs ignored
    rdy_mode = 2;
    x = rand128();
    send(sub_bytes(x), x);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL stall_wait_timeout: out_valid=%b expected 1", out_valid);
    end
    for (int c = 0; c < 20; c++) begin
      check1("stall_out_valid", out_valid, 1'b1);
      check128("stall_result", result, x);
      check1("stall_in_ready", in_ready, 1'b0);
      in_d = rand128();
      in_valid = c[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    wait_idle("stall_drain");
    repeat (3) @(negedge clk);
    check1("post_stall_idle", in_ready, 1'b1);

    // Reset during BUSY, sampled when group 2 of 4 is current
    send(rand128(), 128'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check1("midbusy_rst_in_ready", in_ready, 1'b1);
    check1("midbusy_rst_out_valid", out_valid, 1'b0);
    check128("midbusy_rst_result", result, 128'h0);
    rst = 1'b0;
    x = rand128();
    send(sub_bytes(x), x);
    wait_idle("after_reset");

    n = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30000) begin
      checks++; errors++;
      $display("FAIL sweep_timeout: sweep still running, expected done");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
